// File: rtl/xor_gate_pkg.sv
// xor_gate_pkg: shared constants and helpers for the xor_gate compare primitive.
// Holds the default parameter values and the saturating increment used by the
// optional statistics counters (enabled with XOR_GATE_STATS_EN).
package xor_gate_pkg;

    localparam int XOR_WIDTH_DEF = 1;
    localparam int XOR_CNT_W_DEF = 16;

    // Increment value by one, sticking at max_value instead of wrapping.
    // Callers zero-extend their narrower counters to 32 bits and pass their own
    // all-ones value as max_value, so one function serves every CNT_W.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage : xor_gate_pkg

// File: rtl/xor_popcount.sv
// xor_popcount: combinational population count of a WIDTH-bit word.
// Used by xor_gate to turn the A ^ B difference vector into a Hamming distance.
module xor_popcount #(
    parameter int WIDTH = 1,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [HD_W-1:0]  count_o
);

    // Sum the set bits; HD_W is wide enough to hold WIDTH without overflow.
    always_comb begin
        // NOTE: assigning a default first means every path drives count_o, so no latch is inferred.
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + HD_W'(data_i[i]);
        end
    end

endmodule : xor_popcount

// File: rtl/xor_gate.sv
// xor_gate: parameterised bitwise XOR with a combinational result (C) and a
// registered result path (C_q, hd, parity, out_valid).
// Optional running statistics (sample_cnt, diff_cnt) are built only when the
// macro XOR_GATE_STATS_EN is defined; otherwise the counters read as zero and
// stats_clr is ignored. The port list is the same in both builds.
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = XOR_WIDTH_DEF,
    parameter int CNT_W = XOR_CNT_W_DEF,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             stats_clr,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_q,
    output logic             out_valid,
    output logic [HD_W-1:0]  hd,
    output logic             parity,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] diff_cnt
);

    logic [WIDTH-1:0] xor_d;
    logic [HD_W-1:0]  hd_d;
    logic             parity_d;

    logic [WIDTH-1:0] xor_q;
    logic [HD_W-1:0]  hd_q;
    logic             parity_q;
    logic             valid_q;

    // The difference vector is shared by the combinational output, the
    // registered path and the popcount.
    assign xor_d    = A ^ B;
    assign parity_d = ^xor_d;
    assign C        = xor_d;

    xor_popcount #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_popcount (
        .data_i  (xor_d),
        .count_o (hd_d)
    );

    // Registered result path: capture on in_valid, hold otherwise; out_valid
    // pulses for exactly one cycle per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, avoiding order-dependent races.
            xor_q    <= '0;
            hd_q     <= '0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                xor_q    <= xor_d;
                hd_q     <= hd_d;
                parity_q <= parity_d;
            end
        end
    end

    assign C_q       = xor_q;
    assign hd        = hd_q;
    assign parity    = parity_q;
    assign out_valid = valid_q;

`ifdef XOR_GATE_STATS_EN

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] sample_cnt_d, sample_cnt_q;
    logic [CNT_W-1:0] diff_cnt_d,   diff_cnt_q;

    // Next counter values: clear beats a simultaneous sample; both counters
    // saturate at all-ones.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        diff_cnt_d   = diff_cnt_q;
        if (stats_clr) begin
            sample_cnt_d = '0;
            diff_cnt_d   = '0;
        end else if (in_valid) begin
            sample_cnt_d = CNT_W'(sat_inc(32'(sample_cnt_q), 32'(CNT_MAX)));
            if (|xor_d) begin
                diff_cnt_d = CNT_W'(sat_inc(32'(diff_cnt_q), 32'(CNT_MAX)));
            end
        end
    end

    // Statistics counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            diff_cnt_q   <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            diff_cnt_q   <= diff_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign diff_cnt   = diff_cnt_q;

`else

    // Statistics disabled: no counter flops, outputs tied low, clear ignored.
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign sample_cnt       = '0;
    assign diff_cnt         = '0;

`endif

endmodule : xor_gate

// File: tb/tb_xor_gate.sv
// tb_xor_gate: self-checking bench for xor_gate.
// One WIDTH=1 instance covers the plain-gate truth table; one WIDTH=8,
// CNT_W=4 instance covers the registered path, counters and reset behaviour.
// Expected counter values follow XOR_GATE_STATS_EN the same way the RTL does.
module tb_xor_gate;

`ifdef XOR_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CNT_MAX = 15;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [3:0] hd;
        logic       par;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic [3:0] hd;
        logic       par;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        a1, b1, c1, cq1, ov1, hd1, par1;
    logic [15:0] sc1, dc1;

    logic [7:0] a8, b8, c8, cq8;
    logic       in_valid, stats_clr, ov8, par8;
    logic [3:0] hd8, sc8, dc8;

    int   checks = 0;
    int   errors = 0;
    int   m_samples = 0;
    int   m_diffs   = 0;
    exp_t sb[$];
    vec_t vecs[6];
    logic [7:0] last_c;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(1'b0), .stats_clr(1'b0),
        .C(c1), .C_q(cq1), .out_valid(ov1), .hd(hd1), .parity(par1),
        .sample_cnt(sc1), .diff_cnt(dc1)
    );

    xor_gate #(.WIDTH(8), .CNT_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(in_valid), .stats_clr(stats_clr),
        .C(c8), .C_q(cq8), .out_valid(ov8), .hd(hd8), .parity(par8),
        .sample_cnt(sc8), .diff_cnt(dc8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_sample_cnt"}, 64'(sc8), STATS ? 64'(m_samples) : 64'd0);
        check({tag, "_diff_cnt"},   64'(dc8), STATS ? 64'(m_diffs)   : 64'd0);
    endtask

    // Drive one sample, score the combinational result, push the registered
    // expectation, advance one edge and pop/compare against the DUT output.
    task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic clr,
                          input exp_t e, input string tag);
        exp_t got_exp;
        a8 = a; b8 = b; in_valid = 1'b1; stats_clr = clr;
        #1;
        check({tag, "_C"}, 64'(c8), 64'(e.c));
        sb.push_back(e);
        if (clr) begin
            m_samples = 0;
            m_diffs   = 0;
        end else begin
            m_samples = sat(m_samples);
            if (a != b) m_diffs = sat(m_diffs);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; stats_clr = 1'b0;
        check({tag, "_out_valid"}, 64'(ov8), 64'd1);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: queue empty, expected one entry", tag);
        end else begin
            got_exp = sb.pop_front();
            check({tag, "_C_q"},    64'(cq8),  64'(got_exp.c));
            check({tag, "_hd"},     64'(hd8),  64'(got_exp.hd));
            check({tag, "_parity"}, 64'(par8), 64'(got_exp.par));
            last_c = got_exp.c;
        end
        check_counters(tag);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        vecs[0] = '{8'hF0, 8'h0F, 8'hFF, 4'd8, 1'b0};
        vecs[1] = '{8'h01, 8'h00, 8'h01, 4'd1, 1'b1};
        vecs[2] = '{8'hA5, 8'hA5, 8'h00, 4'd0, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 4'd8, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 8'h26, 4'd3, 1'b1};
        vecs[5] = '{8'h80, 8'h00, 8'h80, 4'd1, 1'b1};

        rst_n = 1'b0; a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; in_valid = 1'b0; stats_clr = 1'b0;
        last_c = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_C_q", 64'(cq8), 64'd0);
        check("rst_hd", 64'(hd8), 64'd0);
        check("rst_parity", 64'(par8), 64'd0);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check_counters("rst");

        // WIDTH=1 truth table on the combinational output.
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            #10;
            check($sformatf("w1_truth_%0d%0d", a1, b1), 64'(c1), (i == 1 || i == 2) ? 64'd1 : 64'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven samples on the WIDTH=8 instance.
        for (int i = 0; i < 6; i++) begin
            e = '{vecs[i].c, vecs[i].hd, vecs[i].par};
            sample(vecs[i].a, vecs[i].b, 1'b0, e, $sformatf("vec%0d", i));
        end

        // Idle cycle: out_valid drops, registered outputs hold.
        a8 = 8'h5A; b8 = 8'h00;
        @(posedge clk); #1;
        check("idle_out_valid", 64'(ov8), 64'd0);
        check("idle_C_q_hold", 64'(cq8), 64'(last_c));
        check("idle_hd_hold", 64'(hd8), 64'd1);
        check("idle_C_tracks", 64'(c8), 64'h5A);

        // Twenty back-to-back unequal samples drive both counters into saturation.
        for (int i = 1; i <= 20; i++) begin
            logic [7:0] av;
            av = 8'(i * 7 + 1);
            e = '{av, 4'($countones(av)), ^av};
            sample(av, 8'h00, 1'b0, e, $sformatf("sat%0d", i));
        end
        check("sat_sample_cnt_final", 64'(sc8), STATS ? 64'd15 : 64'd0);
        check("sat_diff_cnt_final", 64'(dc8), STATS ? 64'd15 : 64'd0);

        // Clear and sample on the same edge: counters zero, datapath still loads.
        e = '{8'h3C, 4'd4, 1'b0};
        sample(8'h3C, 8'h00, 1'b1, e, "clr_valid");

        // Mid-stream asynchronous reset.
        e = '{8'h0F, 4'd4, 1'b0};
        sample(8'h0F, 8'h00, 1'b0, e, "pre_rst");
        a8 = 8'hC3; b8 = 8'h11; in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_samples = 0; m_diffs = 0;
        sb.delete();
        #1;
        check("mid_rst_C_q", 64'(cq8), 64'd0);
        check("mid_rst_hd", 64'(hd8), 64'd0);
        check("mid_rst_parity", 64'(par8), 64'd0);
        check("mid_rst_out_valid", 64'(ov8), 64'd0);
        check_counters("mid_rst");
        check("mid_rst_C", 64'(c8), 64'hD2);
        a8 = 8'h77; b8 = 8'h70;
        #1;
        check("mid_rst_C_tracks", 64'(c8), 64'h07);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First sample after reset release is counted normally.
        e = '{8'h81, 4'd2, 1'b0};
        sample(8'h81, 8'h00, 1'b0, e, "post_rst");
        check("post_rst_sample_one", 64'(sc8), STATS ? 64'd1 : 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_xor_gate

// File: doc/xor_gate.md
# xor_gate

Parameterised bitwise exclusive-OR unit with a combinational result and a registered result path. It compares two operand words and reports the per-bit difference, the Hamming distance and the parity of the difference, with optional running statistics. It sits as a leaf primitive in compare/checksum datapaths. With WIDTH=1, port C behaves as a plain two-input XOR gate.

## Interface
- WIDTH, 1: operand width in bits, legal range 1..64.
- CNT_W, 16: width of the statistics counters, legal range 4..32.
- HD_W, $clog2(WIDTH+1): width of the Hamming-distance output. Derived parameter; not for override.
- clk  input  1  sole clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  when high, A and B are sampled into the registered path.
- stats_clr  input  1  synchronous clear of the statistics counters.
- C  output  WIDTH  combinational A ^ B.
- C_q  output  WIDTH  registered A ^ B.
- out_valid  output  1  high for one cycle per accepted sample.
- hd  output  HD_W  registered popcount of A ^ B.
- parity  output  1  registered reduction XOR of A ^ B.
- sample_cnt  output  CNT_W  number of accepted samples.
- diff_cnt  output  CNT_W  number of accepted samples where A != B.

## Operation
- C = A ^ B at all times. C does not depend on clk or rst_n.
- On a rising edge with in_valid=1, the block loads:
  - C_q with A ^ B;
  - hd with the popcount of A ^ B;
  - parity with ^(A ^ B);
  - out_valid with 1.
- On a rising edge with in_valid=0:
  - out_valid loads 0;
  - C_q, hd and parity hold their previous values.
- Statistics on each edge with in_valid=1:
  - sample_cnt increments by 1;
  - diff_cnt increments by 1 when A != B.
- Both counters saturate at all-ones and never wrap.
- stats_clr=1 zeroes both counters on the next edge. Clear wins over a simultaneous in_valid, so that sample is not counted. The datapath registers still load that sample.
- Reset values: C_q=0, hd=0, parity=0, out_valid=0, sample_cnt=0, diff_cnt=0.

## Timing
- C: zero latency, purely combinational.
- C_q, hd, parity, out_valid: 1-cycle latency from the sampling edge.
- Full throughput: one sample accepted per cycle. No backpressure and no ready signal.
- Counters reflect a sample on the same edge that loads C_q.
- rst_n assertion clears all registers immediately, mid-stream included. The first sample accepted after rst_n deasserts is counted normally.

## Configuration
- Macro XOR_GATE_STATS_EN.
- Defined: sample_cnt and diff_cnt are implemented as specified.
- Undefined: no counter flops are built; sample_cnt and diff_cnt are tied to 0 and stats_clr is ignored. The port list is identical in both builds.

## Structure
- Package xor_gate_pkg holds:
  - default constants XOR_WIDTH_DEF=1 and XOR_CNT_W_DEF=16;
  - a saturating-increment function used by both counters.
- One sub-module, xor_popcount: combinational WIDTH-bit population count producing HD_W bits. It is instantiated once on A ^ B.

## Test plan
- WIDTH=1 truth table, A/B = 0/0, 0/1, 1/0, 1/1, each held 10 ns -> C = 0, 1, 1, 0.
- WIDTH=8, A=8'hF0, B=8'h0F, in_valid=1 for one cycle -> next cycle C_q=8'hFF, hd=8, parity=0, out_valid=1. The cycle after -> out_valid=0 and C_q holds.
- WIDTH=8, A=8'h01, B=8'h00 -> hd=1, parity=1. Then A=B=8'hA5 -> C_q=0, hd=0, and diff_cnt does not increment.
- Stats build with CNT_W=4, 20 consecutive unequal samples -> sample_cnt=15 and diff_cnt=15, saturated with no wrap.
- stats_clr and in_valid high on the same edge -> counters=0 and C_q updated.
- rst_n pulsed low mid-stream -> all registered outputs and counters read 0 immediately, while C still tracks A ^ B.
